mem_store_buffer: RTL and testbench
===================================

# mem_store_buffer

Posted-write buffer between the EX/MEM pipeline register and the single-port data memory of the pipelined MIPS core. Stores are queued in a small FIFO and retired to memory in cycles when the memory port is not needed by a load, so stores never stall on the memory port. Loads read memory directly, with forwarding from the youngest matching queued store. The pipeline sees `st_ready`/`ld_ready` back-pressure only when the buffer is full or a starvation drain is forced.

## Interface
- `DEPTH`, 4: number of store entries; power of two, ≥2.
- `STARVE`, 8: consecutive non-draining cycles with a non-empty buffer before a drain is forced; ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high; clears all state on the next rising edge.
- `st_valid`  in  1  store request from the MEM stage.
- `st_addr`  in  32  store word address (same word indexing as data memory).
- `st_data`  in  32  store data.
- `st_ready`  out  1  store accepted this cycle when `st_valid & st_ready`.
- `ld_valid`  in  1  load request from the MEM stage.
- `ld_addr`  in  32  load word address.
- `ld_ready`  out  1  load serviced this cycle when `ld_valid & ld_ready`.
- `ld_data`  out  32  load result, combinational, same cycle.
- `mem_we`  out  1  data memory write enable.
- `mem_addr`  out  32  data memory address.
- `mem_wd`  out  32  data memory write data.
- `mem_rd`  in  32  data memory combinational read data.
- `empty`  out  1  no queued stores; used by the core before fence or syscall.

## Operation
- Storage: `DEPTH` entries of {addr, data}, a `head` pointer (oldest) and a `tail` pointer (next free), each clog2(DEPTH) bits wide and wrapping modulo `DEPTH`, plus `count` (0..DEPTH).
- `st_ready = (count != DEPTH)`. There is no same-cycle pass-through when full, even if a drain occurs that cycle.
- Enqueue on `st_valid & st_ready`: the entry at `tail` takes {st_addr, st_data}, and `tail` increments.
- No coalescing: repeated stores to the same address occupy separate entries and retire in order.
- Memory port arbitration, combinational, in priority order:
  - **Force drain:** `force = (starve_cnt == STARVE) & (count != 0)`. Then `ld_ready = 0`, `mem_we = 1`, `mem_addr`/`mem_wd` = head entry.
  - **Load:** else if `ld_valid`. Then `ld_ready = 1`, `mem_we = 0`, `mem_addr = ld_addr`.
  - **Drain:** else if `count != 0`. Then `mem_we = 1`, `mem_addr`/`mem_wd` = head entry.
  - **Idle:** else `mem_we = 0`, `mem_addr = 0`, `mem_wd = 0`. `ld_ready` is 1 whenever `force` is 0.
- A drain (forced or normal) increments `head` at the clock edge.
- `count` next value = count + enq − drain. A simultaneous enqueue and drain leaves `count` unchanged.
- Load forwarding: compare `ld_addr` with `addr` of every valid entry (the `count` entries from `head`).
  - On a match, `ld_data` = data of the youngest matching entry (closest to `tail`).
  - Otherwise `ld_data = mem_rd`.
- A store enqueued in the same cycle is not visible to that cycle's load; the pipeline does not issue both in one cycle.
- `starve_cnt` (saturating at `STARVE`) behaves as follows:
  - Increments when `count != 0` and no drain occurred this cycle.
  - Clears on any drain, or when `count == 0`.
- `empty = (count == 0)`.

## Timing
- Reset (synchronous, `rst` high at the edge) clears `head`, `tail`, `count` and `starve_cnt`. Entry contents are don't-care.
- Output values after reset: `st_ready = 1`, `ld_ready = 1`, `empty = 1`, `mem_we = 0`, `mem_addr = 0`, `mem_wd = 0`, `ld_data = mem_rd`.
- `rst` asserted mid-operation discards all queued stores. No memory write occurs in the reset cycle regardless of combinational outputs: the memory's `WE` is qualified by the core.
- Load latency: 0 cycles (combinational through forwarding mux or `mem_rd`).
- Store retirement: earliest in the cycle after acceptance. Worst case with continuous loads is `STARVE` cycles, then one forced drain cycle.
- Full: the store presented while `count == DEPTH` waits (`st_ready = 0`). It is accepted in the cycle after the drain that makes room.
- Pointer wrap: `tail`/`head` wrap from DEPTH−1 to 0. Forwarding must select the correct youngest entry across the wrap.

## Test plan
- **Reset:** drive `rst` for 1 cycle. Then require `empty = 1`, `st_ready = 1`, `mem_we = 0`, `mem_addr = 0`.
- **Basic retire:** store {addr 5, 0xAAAA}, then idle. Require `mem_we = 1`, `mem_addr = 5`, `mem_wd = 0xAAAA` the next cycle, then `empty = 1`.
- **Forwarding:**
  - With loads held continuously: store {7, 0x11}, then store {7, 0x22}, then load 7. Require `ld_data = 0x22` with `mem_we = 0`.
  - Load 8 in the same window requires `ld_data = mem_rd`.
- **Full / back-pressure:**
  - Set up: hold `ld_valid` high and fill 4 stores with addrs 0..3.
  - Fifth store: require `st_ready = 0`.
  - Release loads: retire order 0, 1, 2, 3. The fifth store is accepted the cycle after the first drain.
- **Starvation:**
  - Set up: one queued store and `ld_valid` held high.
  - Cycles 1–8: require `ld_ready = 1`.
  - Cycle 9: require `ld_ready = 0` and `mem_we = 1`; `ld_ready = 1` again in cycle 10.
- **Reset mid-operation:** queue 3 stores, assert `rst` for one cycle. Require `empty = 1` and no further `mem_we` pulses.

Source files
------------

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between EX/MEM and the single-port data memory.
// Loads own the port unless a starvation drain is forced; queued stores forward to loads.
module mem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_ready,
  output logic [31:0] ld_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic          enq;
  logic          drain;
  logic          force_drain;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  // Port arbitration: forced drain > load > opportunistic drain > idle.
  always_comb begin
    st_ready    = (count != FULL);
    enq         = st_valid && st_ready;
    empty       = (count == '0);
    force_drain = (starve_cnt == STARVE_MAX) && !empty;
    ld_ready    = !force_drain;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wd      = '0;
    drain       = 1'b0;
    if (force_drain) begin
      mem_we   = 1'b1;
      mem_addr = addr_q[head];
      mem_wd   = data_q[head];
      drain    = 1'b1;
    end else if (ld_valid) begin
      mem_addr = ld_addr;
    end else if (!empty) begin
      mem_we   = 1'b1;
      mem_addr = addr_q[head];
      mem_wd   = data_q[head];
      drain    = 1'b1;
    end
  end

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
    ld_data = fwd_hit ? fwd_data : mem_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (enq)
        tail <= tail + PW'(1);
      if (drain)
        head <= head + PW'(1);
      count <= count + CW'(enq) - CW'(drain);
      if (drain || empty)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Entry payload needs no reset; validity is carried by head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: directed scenarios plus random traffic against a
// queue-based reference model with its own copy of data memory.
module tb_mem_store_buffer;

  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        empty;

  mem_store_buffer #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_data(ld_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic [31:0] dmem    [64];
  logic [31:0] ref_mem [64];
  ent_t        q [$];
  int          starve;
  int          total;
  int          bad;

  logic        m_drain;
  logic        m_st_ready;
  int          m_n;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wd;

  assign mem_rd = dmem[mem_addr[5:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
  endtask

  // Predict this cycle's outputs from the model and compare at the falling edge.
  task automatic eval();
    logic        frc;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        chk_wd;
    logic [31:0] e_ld;
    @(negedge clk);
    m_n    = q.size();
    frc    = (starve == STARVE) && (m_n != 0);
    m_st_ready = (m_n != DEPTH);
    m_drain = 1'b0;
    chk_wd = 1'b1;
    e_we   = 1'b0;
    e_addr = '0;
    e_wd   = '0;
    if (frc || (!ld_valid && m_n != 0)) begin
      e_we    = 1'b1;
      e_addr  = q[0].a;
      e_wd    = q[0].d;
      m_drain = 1'b1;
    end else if (ld_valid) begin
      e_addr = ld_addr;
      chk_wd = 1'b0;
    end
    check("st_ready", {31'b0, st_ready}, {31'b0, m_st_ready});
    check("ld_ready", {31'b0, ld_ready}, {31'b0, !frc});
    check("empty",    {31'b0, empty},    {31'b0, m_n == 0});
    check("mem_we",   {31'b0, mem_we},   {31'b0, e_we});
    check("mem_addr", mem_addr, e_addr);
    if (chk_wd) check("mem_wd", mem_wd, e_wd);
    if (ld_valid && !frc) begin
      e_ld = ref_mem[ld_addr[5:0]];
      for (int i = 0; i < m_n; i++)
        if (q[i].a == ld_addr) e_ld = q[i].d;
      check("ld_data", ld_data, e_ld);
    end
    c_we   = mem_we;
    c_addr = mem_addr;
    c_wd   = mem_wd;
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) begin
      q.delete();
      starve = 0;
    end else begin
      if (c_we) dmem[c_addr[5:0]] = c_wd;
      if (m_drain) begin
        ref_mem[q[0].a[5:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (st_valid && m_st_ready) q.push_back('{a: st_addr, d: st_data});
      if (m_drain || m_n == 0) starve = 0;
      else if (starve < STARVE) starve++;
    end
    #1;
  endtask

  task automatic step();
    eval();
    commit();
  endtask

  logic [31:0] fdat [5];

  initial begin
    total = 0;
    bad   = 0;
    starve = 0;
    for (int i = 0; i < 64; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    eval();
    check("rst_empty",    {31'b0, empty},    32'd1);
    check("rst_st_ready", {31'b0, st_ready}, 32'd1);
    check("rst_mem_we",   {31'b0, mem_we},   32'd0);
    check("rst_mem_addr", mem_addr,          32'd0);
    commit();

    // basic retire
    drive(1, 5, 32'hAAAA, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    eval();
    check("ret_we",   {31'b0, mem_we}, 32'd1);
    check("ret_addr", mem_addr,        32'd5);
    check("ret_wd",   mem_wd,          32'hAAAA);
    commit();
    eval();
    check("ret_empty", {31'b0, empty}, 32'd1);
    commit();

    // forwarding with loads held
    drive(1, 7, 32'h11, 1, 7);
    step();
    drive(1, 7, 32'h22, 1, 7);
    step();
    drive(0, 0, 0, 1, 7);
    eval();
    check("fwd_youngest", ld_data, 32'h22);
    check("fwd_we",       {31'b0, mem_we}, 32'd0);
    commit();
    drive(0, 0, 0, 1, 8);
    eval();
    check("fwd_miss", ld_data, ref_mem[8]);
    commit();
    drive(0, 0, 0, 0, 0);
    repeat (3) step();
    drive(0, 0, 0, 1, 7);
    eval();
    check("fwd_retired", ld_data, 32'h22);
    commit();

    // full / back-pressure
    for (int i = 0; i < 5; i++) fdat[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      drive(1, i, fdat[i], 1, 20);
      step();
    end
    drive(1, 9, fdat[4], 1, 20);
    eval();
    check("full_st_ready", {31'b0, st_ready}, 32'd0);
    commit();
    drive(1, 9, fdat[4], 0, 20);
    eval();
    check("full_d0_addr", mem_addr, 32'd0);
    check("full_d0_rdy",  {31'b0, st_ready}, 32'd0);
    commit();
    eval();
    check("full_d1_addr", mem_addr, 32'd1);
    check("full_d1_rdy",  {31'b0, st_ready}, 32'd1);
    commit();
    drive(0, 0, 0, 0, 0);
    eval();
    check("full_d2_addr", mem_addr, 32'd2);
    commit();
    eval();
    check("full_d3_addr", mem_addr, 32'd3);
    commit();
    eval();
    check("full_d4_addr", mem_addr, 32'd9);
    check("full_d4_wd",   mem_wd,   fdat[4]);
    commit();
    eval();
    check("full_empty", {31'b0, empty}, 32'd1);
    commit();

    // starvation
    drive(1, 12, 32'h5A5A_1234, 1, 30);
    step();
    drive(0, 0, 0, 1, 30);
    for (int c = 1; c <= STARVE; c++) begin
      eval();
      check("starve_ld_ready", {31'b0, ld_ready}, 32'd1);
      commit();
    end
    eval();
    check("starve_force_rdy", {31'b0, ld_ready}, 32'd0);
    check("starve_force_we",  {31'b0, mem_we},   32'd1);
    check("starve_force_adr", mem_addr,          32'd12);
    commit();
    eval();
    check("starve_after_rdy", {31'b0, ld_ready}, 32'd1);
    check("starve_after_emp", {31'b0, empty},    32'd1);
    commit();

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1, 40 + i, $urandom, 1, 30);
      step();
    end
    drive(0, 0, 0, 1, 30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (5) begin
      eval();
      check("rstmid_we",    {31'b0, mem_we}, 32'd0);
      check("rstmid_empty", {31'b0, empty},  32'd1);
      commit();
    end

    // random traffic, with load-heavy stretches to provoke forced drains
    for (int n = 0; n < 1200; n++) begin
      int ld_pct;
      ld_pct = ((n / 200) % 2 == 1) ? 95 : 55;
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 99) < 45, 32'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < ld_pct, 32'($urandom_range(0, 9)));
      step();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (DEPTH + 2) step();
    for (int i = 0; i < 64; i++) check("mem_image", dmem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
